// File: rtl/button_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : button_cmd_scheduler
// Description : Converts NUM_BUTTONS debounced button levels into a single
//               valid/ready command stream for the message-display scroller.
//               Each button has rising-edge detection, optional hold-to-repeat
//               and a one-deep pending latch. A round-robin arbiter shares
//               the command port among all buttons.
// Ports       : clk         - system clock, all logic on posedge
//               reset       - asynchronous active-high reset, clears all state
//               btn_level   - debounced button levels, synchronous to clk
//               cmd_valid   - command offered to the display controller
//               cmd_ready   - display controller accepts the offered command
//               cmd_id      - index of the button that issued the command
//               cmd_repeat  - 1 = auto-repeat command, 0 = fresh press
//               drop_pulse  - 1-cycle pulse per button when an event was
//                             coalesced into an already pending one
// Revision    : 1.0 - initial release
// ============================================================================
module button_cmd_scheduler #(
  parameter int NUM_BUTTONS  = 4,
  parameter int ID_W         = 2,
  parameter int CNT_W        = 32,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_level,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ID_W-1:0]        cmd_id,
  output logic                   cmd_repeat,
  output logic [NUM_BUTTONS-1:0] drop_pulse
);

  localparam logic [CNT_W-1:0] DELAY_CNT  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_CNT   = CNT_W'(REPEAT_RATE);
  localparam logic             REPEAT_EN  = (REPEAT_DELAY != 0);
  localparam logic [ID_W-1:0]  LAST_RESET = ID_W'(NUM_BUTTONS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [NUM_BUTTONS-1:0] prev;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] rpt_tick;
  logic [NUM_BUTTONS-1:0] set_evt;
  logic [NUM_BUTTONS-1:0] pending;
  logic [NUM_BUTTONS-1:0] pend_rpt;
  logic [NUM_BUTTONS-1:0] grant_oh;
  logic [NUM_BUTTONS-1:0] pending_rot;
  logic                   grant_en;
  logic                   found;
  logic [ID_W-1:0]        grant_idx;
  logic [ID_W-1:0]        last_grant;
  int                     cand;

  // --------------------------------------------------------------------------
  // Edge detection. prev resets to all ones so a button held through reset
  // produces no event until it is released and pressed again.
  // --------------------------------------------------------------------------
  assign rise = btn_level & ~prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '1;
    end else begin
      prev <= btn_level;
    end
  end

  // --------------------------------------------------------------------------
  // Per-button hold counter. phase=0 counts toward the initial delay,
  // phase=1 toward each subsequent repeat period.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_inc;
      logic             phase;

      assign cnt_inc      = cnt + CNT_W'(1);
      assign rpt_tick[gi] = REPEAT_EN && btn_level[gi] &&
                            (cnt_inc == (phase ? RATE_CNT : DELAY_CNT));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt   <= '0;
          phase <= 1'b0;
        end else if (!btn_level[gi]) begin
          cnt   <= '0;
          phase <= 1'b0;
        end else if (rpt_tick[gi]) begin
          cnt   <= '0;
          phase <= 1'b1;
        end else begin
          cnt   <= cnt_inc;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pending latches. A new event on a button overrides a grant of that same
  // button in the same cycle, so the new event is never lost. A rise takes
  // priority over a repeat tick when both occur together.
  // --------------------------------------------------------------------------
  assign set_evt = rise | rpt_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      pend_rpt   <= '0;
      drop_pulse <= '0;
    end else begin
      pending    <= (pending & ~grant_oh) | set_evt;
      pend_rpt   <= (pend_rpt & ~set_evt) | (set_evt & ~rise);
      drop_pulse <= set_evt & pending & ~grant_oh;
    end
  end

  // --------------------------------------------------------------------------
  // Arbiter next-state / grant selection. The scan starts one past the last
  // granted index and wraps, giving round-robin fairness.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    grant_en    = 1'b0;
    grant_idx   = '0;
    found       = 1'b0;
    cand        = 0;
    pending_rot = '0;
    grant_oh    = '0;

    case (state)
      S_IDLE: begin
        if (|pending) begin
          for (int off = 1; off <= NUM_BUTTONS; off++) begin
            cand = int'(last_grant) + off;
            if (cand >= NUM_BUTTONS) begin
              cand = cand - NUM_BUTTONS;
            end
            pending_rot = pending >> cand;
            if (!found && pending_rot[0]) begin
              found     = 1'b1;
              grant_idx = ID_W'(cand);
            end
          end
          grant_en   = 1'b1;
          state_next = S_OFFER;
        end
      end
      S_OFFER: begin
        if (cmd_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    for (int i = 0; i < NUM_BUTTONS; i++) begin
      grant_oh[i] = grant_en && (grant_idx == ID_W'(i));
    end
  end

  // --------------------------------------------------------------------------
  // Arbiter state and command registers. cmd_id/cmd_repeat only change on a
  // grant, so they stay stable for the whole offer.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd_id     <= '0;
      cmd_repeat <= 1'b0;
      last_grant <= LAST_RESET;
    end else begin
      state <= state_next;
      if (grant_en) begin
        cmd_id     <= grant_idx;
        cmd_repeat <= |(pend_rpt & grant_oh);
        last_grant <= grant_idx;
      end
    end
  end

  assign cmd_valid = (state == S_OFFER);

endmodule
`default_nettype wire
